mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 57 +++++
 rtl/mem_stage_load_align.sv | 46 ++++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage: bus widths, stall bit
// positions and polarity, load/store readen codes, hold-FSM states and the
// packed layout of the execute-to-memory bus.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 146;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 104;
  localparam int STALL_W      = 6;

  // Stall vector bit positions owned by this stage.
  localparam int STALL_EX_MEM = 3;  // holds the EX/MEM register
  localparam int STALL_MEM_WB = 4;  // holds the MEM/WB register

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // readen codes, shared with the execute stage.
  typedef enum logic [3:0] {
    RD_NONE = 4'b0000,
    RD_LB   = 4'b0001,
    RD_LBU  = 4'b0010,
    RD_LH   = 4'b0011,
    RD_LHU  = 4'b0100,
    RD_SB   = 4'b0101,
    RD_SH   = 4'b0111,
    RD_LW   = 4'b1111
  } readen_e;

  // LIVE: load data comes straight from the SRAM.
  // HELD: load data comes from the hold buffer while the stage is stalled.
  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } hold_state_e;

  // Execute-to-memory bus, MSB first. readen is kept as raw bits so that
  // unknown codes survive into the stage register.
  typedef struct packed {
    logic [3:0]  readen;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load extraction: picks the byte/half addressed by the low
// address bits out of the SRAM word and sign- or zero-extends it.
//   i_readen : load code (LB/LBU/LH/LHU/LW, anything else -> full word)
//   i_addr   : effective address bits [1:0]
//   i_word   : 32-bit SRAM word
//   o_data   : 32-bit extended load result
// -----------------------------------------------------------------------------
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_readen,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    w_byte = i_word[7:0];
    case (i_addr)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase

    // Halfword ignores addr[0]; misaligned halves are not trapped here.
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    o_data = i_word;
    case (i_readen)
      RD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      RD_LBU:  o_data = {24'h0, w_byte};
      RD_LH:   o_data = {{16{w_half[15]}}, w_half};
      RD_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_word;  // LW and unknown codes
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage MIPS pipeline. Registers the
// execute-to-memory bus, aligns/extends load data from the synchronous data
// SRAM, and keeps that data in a hold buffer while a load is stalled here.
//   clk             : core clock
//   resetn          : asynchronous active-low reset
//   stall           : pipeline stall vector (bit3 EX/MEM, bit4 MEM/WB)
//   ex_to_mem_bus   : packed execute-stage results (see ex_to_mem_t)
//   data_sram_rdata : SRAM read word, valid the cycle after the EX request
//   mem_to_wb_bus   : {hi_we, hi, lo_we, lo, pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus   : {hi_we, hi, lo_we, lo, rf_we, rf_waddr, rf_wdata}
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  ex_to_mem_t  r_stage;
  logic [31:0] r_hold_buf;
  hold_state_e r_state;

  logic        w_bubble;
  logic        w_take;
  logic        w_hold;
  logic        w_is_load;
  logic [31:0] w_src_word;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_unused_stall;

  assign w_bubble = (stall[STALL_EX_MEM] == STOP) && (stall[STALL_MEM_WB] == NO_STOP);
  assign w_take   = (stall[STALL_EX_MEM] == NO_STOP);
  assign w_hold   = (stall[STALL_EX_MEM] == STOP) && (stall[STALL_MEM_WB] == STOP);

  // Other stages' stall bits are not used here.
  assign w_unused_stall = ^{stall[STALL_W-1:STALL_MEM_WB+1], stall[STALL_EX_MEM-1:0]};

  // Stage register: bubble has priority over load; otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stage <= '0;
    end else if (w_bubble) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      r_stage <= '0;
    end else if (w_take) begin
      r_stage <= ex_to_mem_t'(ex_to_mem_bus);
    end
  end

  assign w_is_load = r_stage.ram_en && (r_stage.ram_wen == 4'b0000);

  // Hold FSM. In LIVE the buffer shadows the SRAM every cycle, so on the
  // edge that freezes a load the buffer already has that load's word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the hold buffer is a single register, so it is cleared with the
      // rest of the state; only true memory arrays are left unreset.
      r_state    <= ST_LIVE;
      r_hold_buf <= '0;
    end else begin
      case (r_state)
        ST_LIVE: begin
          r_hold_buf <= data_sram_rdata;
          if (w_hold && w_is_load) r_state <= ST_HELD;
        end
        default: begin
          // Any non-hold edge replaces the register contents.
          if (!w_hold) r_state <= ST_LIVE;
        end
      endcase
    end
  end

  assign w_src_word = (r_state == ST_HELD) ? r_hold_buf : data_sram_rdata;

  load_align u_load_align (
    .i_readen (r_stage.readen),
    .i_addr   (r_stage.ex_result[1:0]),
    .i_word   (w_src_word),
    .o_data   (w_load_data)
  );

  // A bubble has sel_rf_res=0 and ex_result=0, so it drives rf_wdata=0.
  assign w_rf_wdata = r_stage.sel_rf_res ? w_load_data : r_stage.ex_result;

  assign mem_to_wb_bus = {r_stage.hi_we, r_stage.hi, r_stage.lo_we, r_stage.lo,
                          r_stage.pc, r_stage.rf_we, r_stage.rf_waddr, w_rf_wdata};

  assign mem_to_id_bus = {r_stage.hi_we, r_stage.hi, r_stage.lo_we, r_stage.lo,
                          r_stage.rf_we, r_stage.rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. The reference model tracks which
// instruction sits in the stage and the SRAM word seen in its first cycle
// there; expected load results come from plain shift/mask arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic [5:0]   stall;
  logic [145:0] ex_bus;
  logic [31:0]  rdata;
  logic [135:0] wb;
  logic [103:0] id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [145:0] m_instr;
  logic         m_first;
  logic [31:0]  m_data;

  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_HOLD   = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001000;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_bus),
    .data_sram_rdata (rdata),
    .mem_to_wb_bus   (wb),
    .mem_to_id_bus   (id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [145:0] mk(input logic [3:0] readen, input logic hi_we,
                                      input logic [31:0] hi, input logic lo_we,
                                      input logic [31:0] lo, input logic [31:0] pc,
                                      input logic ram_en, input logic [3:0] wen,
                                      input logic sel, input logic rf_we,
                                      input logic [4:0] waddr, input logic [31:0] res);
    return {readen, hi_we, hi, lo_we, lo, pc, ram_en, wen, sel, rf_we, waddr, res};
  endfunction

  function automatic logic [145:0] mk_load(input logic [3:0] code, input logic [31:0] addr);
    return mk(code, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0100, 1'b1, 4'h0, 1'b1, 1'b1,
              5'd9, addr);
  endfunction

  // Load result from the architectural rules, using arithmetic on the word.
  function automatic logic [31:0] ref_load(input logic [3:0] code, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> ((addr % 4) * 8)) & 32'hFF;
    h = (w >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
    case (code)
      4'b0001: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      4'b0010: return b;
      4'b0011: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      4'b0100: return h;
      default: return w;
    endcase
  endfunction

  task automatic compare(input string tag);
    logic [31:0]  wdata;
    logic [135:0] exp_wb;
    logic [103:0] exp_id;
    wdata  = m_instr[38] ? ref_load(m_instr[145:142], m_instr[31:0], m_data) : m_instr[31:0];
    exp_wb = {m_instr[141:44], m_instr[37:32], wdata};
    exp_id = {m_instr[141:76], m_instr[37:32], wdata};
    check({tag, "_wb"}, wb, exp_wb);
    check({tag, "_id"}, {32'h0, id}, {32'h0, exp_id});
  endtask

  // One clock: apply stall/bus, update model at the edge, present the SRAM
  // word for the new cycle, then compare at the falling edge.
  task automatic cycle(input logic [5:0] st, input logic [145:0] ex,
                       input logic [31:0] rd_next, input string tag);
    stall  = st;
    ex_bus = ex;
    @(posedge clk);
    if (st[3] && !st[4]) begin
      m_instr = '0;
      m_first = 1'b1;
    end else if (!st[3]) begin
      m_instr = ex;
      m_first = 1'b1;
    end
    #1 rdata = rd_next;
    @(negedge clk);
    if (m_first) begin
      m_data  = rdata;
      m_first = 1'b0;
    end
    compare(tag);
  endtask

  function automatic logic [145:0] rand_instr();
    logic [3:0] codes [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1111};
    logic [145:0] v;
    case ($urandom_range(0, 3))
      0: v = mk_load(codes[$urandom_range(0, 4)], $urandom);
      1: v = mk_load(4'h8 + 4'($urandom_range(0, 6)), $urandom);
      2: v = mk(($urandom_range(0, 1) != 0) ? 4'b0101 : 4'b0111, 1'($urandom), $urandom,
                1'($urandom), $urandom, $urandom, 1'b1, 4'($urandom_range(1, 15)), 1'b0,
                1'b0, 5'($urandom), $urandom);
      default: v = mk(4'b0000, 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                      1'b0, 4'($urandom), 1'b0, 1'($urandom), 5'($urandom), $urandom);
    endcase
    // Keep pc/hi/lo random for loads too.
    v[140:109] = $urandom;
    v[107:76]  = $urandom;
    v[75:44]   = $urandom;
    return v;
  endfunction

  initial begin
    resetn  = 1'b0;
    stall   = ST_HOLD;
    ex_bus  = mk_load(4'b1111, 32'h10);
    rdata   = 32'hFFFF_FFFF;
    m_instr = '0;
    m_first = 1'b1;
    m_data  = '0;

    // Reset wins over stall and input bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wb", wb, 136'h0);
    check("reset_id", {32'h0, id}, 136'h0);
    resetn = 1'b1;

    // Byte/half/word extraction.
    cycle(ST_RUN, mk_load(4'b0001, 32'h0000_1002), 32'h1280_5678, "lb");
    check("lb_val", {104'h0, wb[31:0]}, {104'h0, 32'hFFFF_FF80});
    cycle(ST_RUN, mk_load(4'b0010, 32'h0000_1002), 32'h1280_5678, "lbu");
    check("lbu_val", {104'h0, wb[31:0]}, {104'h0, 32'h0000_0080});
    cycle(ST_RUN, mk_load(4'b0011, 32'h0000_2002), 32'h8001_7FFF, "lh");
    check("lh_val", {104'h0, wb[31:0]}, {104'h0, 32'hFFFF_8001});
    cycle(ST_RUN, mk_load(4'b0100, 32'h0000_2003), 32'h8001_7FFF, "lhu");
    check("lhu_val", {104'h0, wb[31:0]}, {104'h0, 32'h0000_8001});
    cycle(ST_RUN, mk_load(4'b1111, 32'h0000_2000), 32'h8001_7FFF, "lw");
    check("lw_val", {104'h0, wb[31:0]}, {104'h0, 32'h8001_7FFF});

    // Stalled load keeps its data while the SRAM output changes.
    cycle(ST_RUN, mk_load(4'b1111, 32'h0000_3000), 32'hDEAD_BEEF, "lw_hold0");
    for (int i = 0; i < 3; i++) begin
      cycle(ST_HOLD, mk_load(4'b0001, 32'h0), 32'h0000_0000, "lw_hold");
      check("lw_hold_val", {104'h0, wb[31:0]}, {104'h0, 32'hDEAD_BEEF});
    end
    // Released: new load follows the live SRAM word.
    cycle(ST_RUN, mk_load(4'b1111, 32'h0000_3004), 32'h1111_2222, "lw_release");
    check("release_val", {104'h0, wb[31:0]}, {104'h0, 32'h1111_2222});

    // Bubble insertion.
    cycle(ST_RUN, mk(4'b0000, 1'b1, 32'h5, 1'b1, 32'h6, 32'h400, 1'b0, 4'h0, 1'b0, 1'b1,
                     5'd7, 32'h99), 32'h0, "alu_pre");
    cycle(ST_BUBBLE, mk_load(4'b1111, 32'h4), 32'h1234_5678, "bubble");
    check("bubble_val", wb, 136'h0);

    // Non-load result and hi pass-through on both buses.
    cycle(ST_RUN, mk(4'b0000, 1'b1, 32'hAA, 1'b0, 32'h0, 32'h500, 1'b0, 4'h0, 1'b0, 1'b1,
                     5'd5, 32'h1234), 32'hFFFF_0000, "alu");
    check("alu_wdata", {104'h0, wb[31:0]}, {104'h0, 32'h0000_1234});
    check("alu_hi_wb", {104'h0, wb[134:103]}, {104'h0, 32'h0000_00AA});
    check("alu_hi_id", {104'h0, id[102:71]}, {104'h0, 32'h0000_00AA});

    // Asynchronous reset in the middle of a held load.
    cycle(ST_RUN, mk_load(4'b1111, 32'h40), 32'h5555_AAAA, "pre_rst");
    cycle(ST_HOLD, '0, 32'h0, "held_rst");
    #2 resetn = 1'b0;
    #1;
    check("async_rst_wb", wb, 136'h0);
    check("async_rst_id", {32'h0, id}, 136'h0);
    m_instr = '0;
    m_first = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cycle(ST_RUN, mk_load(4'b1111, 32'h44), 32'hCAFE_F00D, "post_rst");
    check("post_rst_live", {104'h0, wb[31:0]}, {104'h0, 32'hCAFE_F00D});
    cycle(ST_HOLD, '0, 32'h0, "post_rst_hold");
    check("post_rst_hold_val", {104'h0, wb[31:0]}, {104'h0, 32'hCAFE_F00D});

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(6'($urandom), rand_instr(), $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: the run must end on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
